// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (types only).
// Backpressure: n/a.
package uart_pkg;

  // Data-size select (cr_ds_i)
  localparam logic DS_8BIT = 1'b0;
  localparam logic DS_7BIT = 1'b1;

  // Bit positions inside an 11-bit received frame
  localparam int FRAME_BITS     = 11;
  localparam int FRAME_DATA_LSB = 0;
  localparam int FRAME_DATA_MSB = 7;

  // One character time is a full frame of bit periods
  localparam int BITS_PER_CHAR  = 11;

  // One receive FIFO entry
  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  // RX idle-timeout tracker states
  typedef enum logic [1:0] {
    TO_IDLE    = 2'd0,
    TO_ARMED   = 2'd1,
    TO_EXPIRED = 2'd2
  } to_state_t;

endpackage

// File: rtl/rx_backend_if.sv
// Frame hand-off from rx_frontend to rx_backend.
// Latency: n/a (wires only); valid is a one-cycle strobe.
// Backpressure: none; the receiver must accept or drop the frame.
//   frame      : 11-bit received frame, data LSB-first in [7:0]
//   parity_err : parity error of frame
//   frame_err  : stop-bit error of frame
//   valid      : frame/error fields valid this cycle
interface rx_backend_if;
  import uart_pkg::*;

  logic [FRAME_BITS-1:0] frame;
  logic                  parity_err;
  logic                  frame_err;
  logic                  valid;

  modport master (output frame, parity_err, frame_err, valid);
  modport slave  (input  frame, parity_err, frame_err, valid);
endinterface

// File: rtl/rx_fifo.sv
// Generic synchronous FIFO with level count and registered pointers.
// Latency: push visible on dout_o/level_o the cycle after push_i.
// Backpressure: push ignored when full unless pop_i the same cycle; pop ignored when empty.
//   push_i/din_i : write request and data     pop_i   : remove head entry
//   dout_o       : head entry (stale when empty)
//   full_o/empty_o/level_o : occupancy         push_ok_o : push accepted this cycle
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       push_ok_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [LW-1:0]    level;
  logic             push_ok, pop_ok;

  assign full_o    = (level == LW'(DEPTH));
  assign empty_o   = (level == '0);
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign push_ok   = push_i & (~full_o | pop_i);
  assign pop_ok    = pop_i & ~empty_o;
  assign push_ok_o = push_ok;
  assign level_o   = level;
  assign dout_o    = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/rx_backend.sv
// RX backend: frame data extraction, receive FIFO, overrun, RX interrupt, optional idle timeout.
// Latency: frame strobe -> rxne_o/rxdr_o next cycle; rd_i -> next head next cycle.
// Backpressure: none upstream; frames arriving at a full FIFO without a same-cycle read are dropped and flag ore_o.
//   clk_i, rst_i (sync active-low)   fe : frame hand-off (rx_backend_if.slave)
//   cr_clk_div_i, cr_ds_i : config   rd_i, sr_clr_i : register-side pop / sticky clear
//   rxdr_o, pe_o, fe_o : head entry (0 when empty)   rxne_o, rxf_o, ore_o, level_o, timeout_o, irq_o : status
// Optional feature: define WBUART_RX_TIMEOUT_EN to build the idle-timeout tracker.
module rx_backend
  import uart_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int IRQ_THRESHOLD = 1,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [15:0]                cr_clk_div_i,
  input  logic                       cr_ds_i,
  rx_backend_if.slave                fe,
  input  logic                       rd_i,
  input  logic                       sr_clr_i,
  output logic [7:0]                 rxdr_o,
  output logic                       pe_o,
  output logic                       fe_o,
  output logic                       rxne_o,
  output logic                       rxf_o,
  output logic                       ore_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       timeout_o,
  output logic                       irq_o
);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] IRQ_LEVEL = LW'(IRQ_THRESHOLD);

  rx_entry_t     entry_in, head;
  logic [$bits(rx_entry_t)-1:0] head_raw;
  logic          full, empty, push_ok;
  logic [LW-1:0] level;
  logic          ore;
  logic          ore_set;

  // Frame bits above the data byte (stop/parity positions) are not stored
  logic unused_frame_bits;
  assign unused_frame_bits = ^fe.frame[FRAME_BITS-1:FRAME_DATA_MSB+1];

  always_comb begin
    entry_in      = '0;
    entry_in.fe   = fe.frame_err;
    entry_in.pe   = fe.parity_err;
    entry_in.data = fe.frame[FRAME_DATA_MSB:FRAME_DATA_LSB];
    if (cr_ds_i == DS_7BIT) entry_in.data[7] = 1'b0;
  end

  rx_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (fe.valid),
    .din_i     (entry_in),
    .pop_i     (rd_i),
    .dout_o    (head_raw),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level),
    .push_ok_o (push_ok)
  );

  assign head = rx_entry_t'(head_raw);

  // Any strobe the FIFO refused is an overrun
  assign ore_set = fe.valid & ~push_ok;

  always_ff @(posedge clk_i) begin
    if (!rst_i) ore <= 1'b0;
    else        ore <= ore_set | (ore & ~sr_clr_i);
  end

`ifdef WBUART_RX_TIMEOUT_EN
  localparam int TO_BITS = BITS_PER_CHAR * TIMEOUT_CHARS;
  localparam int BW      = $clog2(TO_BITS + 1);

  to_state_t     state, state_nxt;
  logic [15:0]   presc;
  logic [BW-1:0] bit_cnt;
  logic [15:0]   div_m1;
  logic          tick, pop_ok, empty_nxt, restart, count_en;

  assign pop_ok    = rd_i & ~empty;
  // FIFO empty after this edge: nothing pushed and either already empty or last entry popped
  assign empty_nxt = ~push_ok & (empty | (pop_ok & (level == LW'(1))));
  assign div_m1    = (cr_clk_div_i == 16'd0) ? 16'd0 : cr_clk_div_i - 16'd1;
  assign tick      = (presc == div_m1);

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    count_en  = 1'b0;
    case (state)
      TO_IDLE: begin
        if (push_ok) begin
          state_nxt = TO_ARMED;
          restart   = 1'b1;
        end
      end
      TO_ARMED: begin
        if (empty_nxt) begin
          state_nxt = TO_IDLE;
          restart   = 1'b1;
        end else if (push_ok | pop_ok) begin
          restart = 1'b1;
        end else begin
          count_en = 1'b1;
          if (tick && bit_cnt == BW'(TO_BITS - 1)) state_nxt = TO_EXPIRED;
        end
      end
      TO_EXPIRED: begin
        if (pop_ok | sr_clr_i) begin
          state_nxt = empty_nxt ? TO_IDLE : TO_ARMED;
          restart   = 1'b1;
        end else if (push_ok) begin
          restart = 1'b1;
        end
      end
      default: state_nxt = TO_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= TO_IDLE;
      presc   <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        presc   <= '0;
        bit_cnt <= '0;
      end else if (count_en) begin
        if (tick) begin
          presc   <= '0;
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          presc <= presc + 16'd1;
        end
      end
    end
  end

  assign timeout_o = (state == TO_EXPIRED);
`else
  logic unused_cfg;
  assign unused_cfg = ^cr_clk_div_i;
  assign timeout_o  = 1'b0;
`endif

  assign rxdr_o  = empty ? 8'h00 : head.data;
  assign pe_o    = ~empty & head.pe;
  assign fe_o    = ~empty & head.fe;
  assign rxne_o  = ~empty;
  assign rxf_o   = full;
  assign ore_o   = ore;
  assign level_o = level;
  assign irq_o   = (level >= IRQ_LEVEL) | ore | timeout_o;
endmodule

// File: tb/tb_rx_backend.sv
module tb_rx_backend;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int THR   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] clk_div = 16'd4;
  logic        ds = 1'b0;
  logic        rd = 1'b0;
  logic        sr_clr = 1'b0;
  logic [7:0]  rxdr;
  logic        pe, fe_flag, rxne, rxf, ore, timeout, irq;
  logic [3:0]  level;

  rx_backend_if fe_if ();

  rx_backend #(.DEPTH(DEPTH), .IRQ_THRESHOLD(THR), .TIMEOUT_CHARS(4)) dut (
    .clk_i(clk), .rst_i(rst), .cr_clk_div_i(clk_div), .cr_ds_i(ds), .fe(fe_if),
    .rd_i(rd), .sr_clr_i(sr_clr), .rxdr_o(rxdr), .pe_o(pe), .fe_o(fe_flag),
    .rxne_o(rxne), .rxf_o(rxf), .ore_o(ore), .level_o(level),
    .timeout_o(timeout), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  rx_entry_t m_q[$];
  bit        m_ore = 0;
  bit        cmp_en = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_ore = 0;
    end else begin
      bit was_full, drop;
      rx_entry_t e;
      was_full = (m_q.size() == DEPTH);
      drop     = fe_if.valid && was_full && !rd;
      e.fe     = fe_if.frame_err;
      e.pe     = fe_if.parity_err;
      e.data   = ds ? {1'b0, fe_if.frame[6:0]} : fe_if.frame[7:0];
      if (rd && m_q.size() > 0) void'(m_q.pop_front());
      if (fe_if.valid && !drop) m_q.push_back(e);
      m_ore = drop || (m_ore && !sr_clr);
    end
  end

  // Single compare process: every cycle, outputs vs model
  always @(negedge clk) begin
    if (cmp_en) begin
      bit ne;
      ne = (m_q.size() > 0);
      check("m_rxdr",  {24'd0, rxdr},  ne ? {24'd0, m_q[0].data} : 32'd0);
      check("m_pe",    {31'd0, pe},      ne ? {31'd0, m_q[0].pe} : 32'd0);
      check("m_fe",    {31'd0, fe_flag}, ne ? {31'd0, m_q[0].fe} : 32'd0);
      check("m_rxne",  {31'd0, rxne},  {31'd0, ne});
      check("m_rxf",   {31'd0, rxf},   (m_q.size() == DEPTH) ? 32'd1 : 32'd0);
      check("m_ore",   {31'd0, ore},   {31'd0, m_ore});
      check("m_level", {28'd0, level}, m_q.size());
`ifndef WBUART_RX_TIMEOUT_EN
      check("m_timeout", {31'd0, timeout}, 32'd0);
      check("m_irq", {31'd0, irq}, ((m_q.size() >= THR) || m_ore) ? 32'd1 : 32'd0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input logic [10:0] f, input logic p, input logic e);
    fe_if.frame = f; fe_if.parity_err = p; fe_if.frame_err = e; fe_if.valid = 1'b1;
    cyc();
    fe_if.valid = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    cyc();
    rd = 1'b0;
  endtask

  initial begin
    fe_if.frame = '0; fe_if.parity_err = 0; fe_if.frame_err = 0; fe_if.valid = 0;
    cyc();
    cmp_en = 1;
    cyc(); cyc();
    check("rst_rxne", {31'd0, rxne}, 0);
    check("rst_level", {28'd0, level}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_ore", {31'd0, ore}, 0);
    rst = 1'b1;
    cyc();

    // 1: basic push
    ds = 0;
    push(11'h0A5, 0, 0);
    check("t1_rxne", {31'd0, rxne}, 1);
    check("t1_rxdr", {24'd0, rxdr}, 32'hA5);
    check("t1_level", {28'd0, level}, 1);
    check("t1_irq", {31'd0, irq}, 1);
    pop();
    check("t1_empty", {31'd0, rxne}, 0);

    // 2: 7-bit data with parity error
    ds = 1;
    push(11'h0FF, 1, 0);
    check("t2_rxdr", {24'd0, rxdr}, 32'h7F);
    check("t2_pe", {31'd0, pe}, 1);
    check("t2_fe", {31'd0, fe_flag}, 0);
    pop();
    check("t2_rxne", {31'd0, rxne}, 0);
    check("t2_pe0", {31'd0, pe}, 0);
    ds = 0;

    // 3: fill, overrun, drain
    for (int i = 1; i <= 8; i++) push(11'(i), 0, 0);
    check("t3_rxf", {31'd0, rxf}, 1);
    check("t3_ore0", {31'd0, ore}, 0);
    push(11'h009, 0, 0);
    check("t3_ore", {31'd0, ore}, 1);
    check("t3_head", {24'd0, rxdr}, 32'h01);
    check("t3_level", {28'd0, level}, 8);

    // 5: clear racing a fresh overrun, then clear alone
    sr_clr = 1;
    push(11'h00A, 0, 0);
    sr_clr = 0;
    check("t5_ore_hold", {31'd0, ore}, 1);
    sr_clr = 1; cyc(); sr_clr = 0;
    check("t5_ore_clr", {31'd0, ore}, 0);

    for (int i = 1; i <= 8; i++) begin
      check("t3_pop", {24'd0, rxdr}, i);
      pop();
    end
    check("t3_drained", {31'd0, rxne}, 0);

    // 4: push+pop on full
    for (int i = 0; i < 8; i++) push(11'h10 + 11'(i), 0, 0);
    rd = 1;
    push(11'h055, 0, 1);
    rd = 0;
    check("t4_level", {28'd0, level}, 8);
    check("t4_ore", {31'd0, ore}, 0);
    check("t4_head", {24'd0, rxdr}, 32'h11);
    for (int i = 0; i < 7; i++) pop();
    check("t4_last", {24'd0, rxdr}, 32'h55);
    check("t4_last_fe", {31'd0, fe_flag}, 1);
    pop();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      fe_if.frame      = 11'($urandom);
      fe_if.parity_err = 1'($urandom);
      fe_if.frame_err  = 1'($urandom);
      fe_if.valid      = ($urandom_range(0, 99) < 55);
      rd               = ($urandom_range(0, 99) < 40);
      sr_clr           = ($urandom_range(0, 99) < 8);
      ds               = 1'($urandom);
      rst              = ($urandom_range(0, 199) != 0);
      cyc();
    end
    fe_if.valid = 0; rd = 0; sr_clr = 0; ds = 0; rst = 1;
    cyc();
    for (int i = 0; i < 9; i++) pop();

`ifdef WBUART_RX_TIMEOUT_EN
    // 6: idle timeout with 4 cycles/bit, 4 chars -> 176 cycles
    cyc();
    clk_div = 16'd4;
    push(11'h033, 0, 0);
    repeat (175) cyc();
    check("t6_not_yet", {31'd0, timeout}, 0);
    cyc();
    check("t6_timeout", {31'd0, timeout}, 1);
    check("t6_irq", {31'd0, irq}, 1);
    pop();
    check("t6_cleared", {31'd0, timeout}, 0);
    push(11'h044, 0, 0);
    repeat (50) cyc();
    rst = 0;
    cyc();
    check("t6_rst_rxne", {31'd0, rxne}, 0);
    check("t6_rst_to", {31'd0, timeout}, 0);
    check("t6_rst_irq", {31'd0, irq}, 0);
    check("t6_rst_rxdr", {24'd0, rxdr}, 0);
    rst = 1;
    cyc();
`endif

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
